// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: tracks oversample edge and bit position, strobes the RX datapath.
// Optional macro UART_RX_ERR_FLAGS_EN adds par_err_flag / stp_err_flag drop-cause pulses.
module uart_rx_fsm #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      rx_in,
   input  logic                      par_en,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic                      strt_glitch,
   input  logic                      par_err,
   input  logic                      stp_err,
   output logic [PRESCALE_WIDTH-1:0] edge_cnt,
   output logic [3:0]                bit_cnt,
   output logic                      dat_samp_en,
   output logic                      strt_chk_en,
   output logic                      par_chk_en,
   output logic                      stp_chk_en,
   output logic                      deser_en,
`ifdef UART_RX_ERR_FLAGS_EN
   output logic                      par_err_flag,
   output logic                      stp_err_flag,
`endif
   output logic                      data_valid
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic [3:0]                LP_LAST_DATA_BIT = 4'(DATA_WIDTH);
   localparam logic [PRESCALE_WIDTH-1:0] LP_ONE           = PRESCALE_WIDTH'(1);

   state_t                    r_state;
   state_t                    w_next_state;
   logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
   logic [PRESCALE_WIDTH-1:0] r_prescale;
   logic [3:0]                r_bit_cnt;
   logic                      r_par_en;
   logic                      r_data_valid;
   logic                      w_eob;
   logic                      w_frame_start;
   logic                      w_frame_ok;

   assign w_eob      = (r_edge_cnt == r_prescale - LP_ONE);
   assign edge_cnt   = r_edge_cnt;
   assign bit_cnt    = r_bit_cnt;
   assign data_valid = r_data_valid;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // A frame starts either from IDLE or directly out of STOP when the next start bit is already low.
   always_comb begin
      w_next_state  = r_state;
      w_frame_start = 1'b0;
      w_frame_ok    = 1'b0;
      case (r_state)
         IDLE: begin
            if (!rx_in) begin
               w_next_state  = START;
               w_frame_start = 1'b1;
            end
         end
         START: begin
            if (w_eob) begin
               w_next_state = strt_glitch ? IDLE : DATA;
            end
         end
         DATA: begin
            if (w_eob && (r_bit_cnt == LP_LAST_DATA_BIT)) begin
               w_next_state = r_par_en ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (w_eob) begin
               w_next_state = par_err ? IDLE : STOP;
            end
         end
         STOP: begin
            if (w_eob) begin
               w_frame_ok = !stp_err;
               if (!rx_in) begin
                  w_next_state  = START;
                  w_frame_start = 1'b1;
               end else begin
                  w_next_state = IDLE;
               end
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      dat_samp_en = (r_state != IDLE);
      strt_chk_en = 1'b0;
      par_chk_en  = 1'b0;
      stp_chk_en  = 1'b0;
      deser_en    = 1'b0;
      case (r_state)
         START:   strt_chk_en = w_eob;
         DATA:    deser_en    = w_eob;
         PARITY:  par_chk_en  = w_eob;
         STOP:    stp_chk_en  = w_eob;
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_edge_cnt   <= '0;
         r_bit_cnt    <= '0;
         r_data_valid <= 1'b0;
      end else begin
         r_data_valid <= w_frame_ok;
         if ((w_next_state == IDLE) || w_frame_start) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
         end else if (w_eob) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + 4'd1;
         end else begin
            r_edge_cnt <= r_edge_cnt + LP_ONE;
         end
      end
   end

   // Frame configuration is frozen at frame start so mid-frame changes cannot shift bit timing.
   always_ff @(posedge CLK) begin
      if (w_frame_start) begin
         r_prescale <= prescale;
         r_par_en   <= par_en;
      end
   end

`ifdef UART_RX_ERR_FLAGS_EN
   logic r_par_err_flag;
   logic r_stp_err_flag;

   assign par_err_flag = r_par_err_flag;
   assign stp_err_flag = r_stp_err_flag;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_par_err_flag <= 1'b0;
         r_stp_err_flag <= 1'b0;
      end else begin
         r_par_err_flag <= (r_state == PARITY) && w_eob && par_err;
         r_stp_err_flag <= (r_state == STOP) && w_eob && stp_err;
      end
   end
`endif

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
Frame-sequencing controller for the UART receiver. It tracks the oversampling edge count and the bit count. It enables the data sampler, start/parity/stop checkers and deserializer at the right instants, and issues data_valid for each clean frame. It sits between the raw RX line and the RX datapath blocks, which are combinational checkers plus the sampler and deserializer.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_WIDTH, 6, width of prescale and edge_cnt

Ports:
CLK  in  1  receiver oversampling clock
RST  in  1  synchronous, active-low reset
rx_in  in  1  serial line, idle high
par_en  in  1  frame carries a parity bit
prescale  in  PRESCALE_WIDTH  oversampling ratio, supported 8/16/32
strt_glitch  in  1  start checker result, 1 = false start
par_err  in  1  parity checker result
stp_err  in  1  stop checker result
edge_cnt  out  PRESCALE_WIDTH  oversample index within current bit, to sampler
bit_cnt  out  4  bit index within frame (0 = start bit)
dat_samp_en  out  1  sampler enable
strt_chk_en  out  1  start checker enable
par_chk_en  out  1  parity checker enable
stp_chk_en  out  1  stop checker enable
deser_en  out  1  deserializer shift strobe
data_valid  out  1  frame accepted, one-cycle pulse

Behaviour:
- One clock, CLK. Reset is synchronous and active-low on RST. With RST=0 at a CLK edge: state=IDLE, edge_cnt=0, bit_cnt=0, all enables and data_valid=0. This applies mid-frame too; the partial frame is discarded with no data_valid.
- Frame start: prescale and par_en are latched when leaving IDLE. Changes to either mid-frame have no effect until the next frame.
- "End of bit" (EOB) means edge_cnt == latched_prescale-1.
- edge_cnt increments every cycle outside IDLE and wraps to 0 at EOB. bit_cnt increments at each EOB.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: counters held at 0. If rx_in==0 at a CLK edge, go to START with edge_cnt=0.
- START: strt_chk_en=1 during the EOB cycle.
  - strt_glitch=1 at EOB -> IDLE.
  - Otherwise -> DATA.
- DATA: deser_en=1 during each EOB cycle, giving exactly DATA_WIDTH pulses per frame. After the DATA_WIDTH-th EOB -> PARITY if latched par_en, else STOP.
- PARITY: par_chk_en=1 during the EOB cycle.
  - par_err=1 -> IDLE, frame dropped.
  - Otherwise -> STOP.
- STOP: stp_chk_en=1 during the EOB cycle.
  - stp_err=1 -> frame dropped.
  - Otherwise data_valid=1 (registered) in the next cycle, exactly one cycle wide.
  - Next state after STOP EOB: if rx_in==0 at that edge, go straight to START (back-to-back frame, edge_cnt=0). Otherwise go to IDLE.
- Checker results are sampled only in their enable cycle. They are ignored at all other times.
- dat_samp_en=1 in every state except IDLE.
- All enables are combinational from state and edge_cnt, so they are glitch-free and change only after CLK edges.
- Latency: for DATA_WIDTH=8, par_en=1, prescale=8, data_valid asserts 88 cycles after the cycle that detects the falling start edge. That is 11 bits × 8 cycles.
- Unsupported prescale (<4 or odd): behaviour undefined; no protection is required.

Optional Feature:
Macro UART_RX_ERR_FLAGS_EN.
- When defined: adds outputs par_err_flag and stp_err_flag. Each is a registered one-cycle pulse, asserted the cycle after a frame is dropped for that cause. Both reset to 0.
- When undefined: these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- Reset mid-DATA (prescale=8, bit_cnt=4): drive RST=0 for one edge -> next cycle IDLE, edge_cnt=0, bit_cnt=0, no data_valid. The following frame 0xA5 is received normally.
- Frame 0x3C, par_en=0, prescale=16 -> exactly 8 deser_en pulses, each at edge_cnt=15. data_valid pulses once, 160 cycles after start detect.
- Glitch start: rx_in low for 2 cycles, strt_glitch=1 at EOB -> return to IDLE. No deser_en, no data_valid.
- par_en=1, par_err forced 1 at PARITY EOB -> no stp_chk_en, no data_valid, IDLE next. With macro: par_err_flag pulses once.
- stp_err=1 at STOP EOB -> no data_valid. With macro: stp_err_flag pulses once.
- Back-to-back frames 0x55, 0xAA with rx_in=0 at STOP EOB, prescale=8 -> START entered directly. Two data_valid pulses spaced 80 cycles apart (par_en=0).
